// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the FIFO-buffered UART transmitter.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int frame_len(input int div, input int data_bits,
                                   input int parity, input int stop_bits);
    return div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Circular-buffer FIFO with occupancy count; head entry is readable without a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic           pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]    count_o,
  output logic           full_o,
  output logic           empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a transmit FIFO; back-to-back frames with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          UART_TXD
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 pop, full, empty, last, load;
  logic [DATA_BITS-1:0] head;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign tx_ready = ~full;
  assign tx_busy  = (state_q != IDLE);
  assign UART_TXD = txd_q;
  assign last     = (baud_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    load    = 1'b0;
    if (state_q != IDLE) baud_d = last ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE:  load = ~empty;
      START: if (last) begin
        state_d = DATA;
        txd_d   = shift_q[0];
        bit_d   = '0;
      end
      DATA: if (last) begin
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d = '0;
          if (PARITY != PAR_NONE) begin
            state_d = PAR;
            txd_d   = par_q;
          end else begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          txd_d   = shift_q[1];
        end
      end
      PAR: if (last) begin
        state_d = STOP;
        txd_d   = 1'b1;
        bit_d   = '0;
      end
      STOP: if (last) begin
        if (bit_q == 4'(STOP_BITS - 1)) begin
          state_d = IDLE;
          load    = ~empty;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame load is shared by the idle start and the zero-gap restart out of STOP.
    if (load) begin
      state_d = START;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == PAR_ODD);
      txd_d   = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
    end
    pop = load;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations checked cycle-by-cycle against an expected-waveform model.
module tb_uart_tx_fifo;
  localparam int N     = 4;
  localparam int DIV   = 10;
  localparam int DEPTH = 16;
  localparam int PARV  [N] = '{0, 2, 1, 0};
  localparam int STOPV [N] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d   [N];
  logic       vld [N];
  logic       rdy [N];
  logic       busy[N];
  logic       txd [N];
  logic [4:0] cnt [N];

  int checks = 0;
  int failures = 0;
  bit started = 0;

  logic [7:0] fq [N][$];
  bit         wq [N][$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLOCK_50(clk), .RESET(rst), .tx_data(d[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .fifo_count(cnt[0]), .tx_busy(busy[0]), .UART_TXD(txd[0]));
  uart_tx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .PARITY(2), .STOP_BITS(1)) u1 (
    .CLOCK_50(clk), .RESET(rst), .tx_data(d[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .fifo_count(cnt[1]), .tx_busy(busy[1]), .UART_TXD(txd[1]));
  uart_tx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .PARITY(1), .STOP_BITS(1)) u2 (
    .CLOCK_50(clk), .RESET(rst), .tx_data(d[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .fifo_count(cnt[2]), .tx_busy(busy[2]), .UART_TXD(txd[2]));
  uart_tx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .PARITY(0), .STOP_BITS(2)) u3 (
    .CLOCK_50(clk), .RESET(rst), .tx_data(d[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .fifo_count(cnt[3]), .tx_busy(busy[3]), .UART_TXD(txd[3]));

  task automatic check(input string name, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Model: a byte queue plus a queue of per-cycle line levels for the frame in flight.
  always @(posedge clk) begin
    int c0;
    logic [7:0] b;
    bit pb;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        fq[i].delete();
        wq[i].delete();
      end else begin
        c0 = fq[i].size();
        if (wq[i].size() > 0) void'(wq[i].pop_front());
        if (wq[i].size() == 0 && fq[i].size() > 0) begin
          b  = fq[i].pop_front();
          pb = (^b) ^ (PARV[i] == 1);
          for (int k = 0; k < DIV; k++) wq[i].push_back(1'b0);
          for (int j = 0; j < 8; j++)
            for (int k = 0; k < DIV; k++) wq[i].push_back(b[j]);
          if (PARV[i] != 0)
            for (int k = 0; k < DIV; k++) wq[i].push_back(pb);
          for (int k = 0; k < DIV * STOPV[i]; k++) wq[i].push_back(1'b1);
        end
        if (vld[i] && c0 < DEPTH) fq[i].push_back(d[i]);
      end
    end
    if (rst) started = 1;
    #1;
    if (started) begin
      for (int i = 0; i < N; i++) begin
        check("txd",   i, int'(txd[i]),  (wq[i].size() > 0) ? int'(wq[i][0]) : 1);
        check("busy",  i, int'(busy[i]), int'(wq[i].size() > 0));
        check("count", i, int'(cnt[i]),  fq[i].size());
        check("ready", i, int'(rdy[i]),  int'(fq[i].size() < DEPTH));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit r;
    int acc;
    for (int i = 0; i < N; i++) begin vld[i] = 1'b0; d[i] = 8'h00; end
    tick(1);
    rst = 1'b1; tick(2); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("rst_txd", i, int'(txd[i]), 1);
      check("rst_cnt", i, int'(cnt[i]), 0);
      check("rst_rdy", i, int'(rdy[i]), 1);
      check("rst_busy", i, int'(busy[i]), 0);
    end
    tick(3);

    // Tests 1-4 in parallel: one write per instance at edge k.
    d[0] = 8'h55; d[1] = 8'h07; d[2] = 8'h07; d[3] = 8'hFF;
    for (int i = 0; i < N; i++) vld[i] = 1'b1;
    tick(1);
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      check("k_txd", i, int'(txd[i]), 1);
      check("k_cnt", i, int'(cnt[i]), 1);
    end
    tick(1);
    for (int j = 0; j < 12; j++) begin
      if (j < 10) check("slot55", j, int'(txd[0]), j % 2);
      if (j == 0) for (int i = 1; i < N; i++) check("start", i, int'(txd[i]), 0);
      if (j == 9) begin
        check("par_even", 1, int'(txd[1]), 1);
        check("par_odd",  2, int'(txd[2]), 0);
      end
      if (j >= 1 && j <= 10) check("ff_high", j, int'(txd[3]), 1);
      if (j == 10) begin
        check("busy100", 0, int'(busy[0]), 0);
        for (int i = 1; i < N; i++) check("busy100", i, int'(busy[i]), 1);
      end
      if (j == 11) for (int i = 1; i < N; i++) check("busy110", i, int'(busy[i]), 0);
      tick(10);
    end
    tick(20);

    // Test 5: hold valid 30 cycles on instance 0 with incrementing data.
    acc = 0; d[0] = 8'h00; vld[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      r = rdy[0];
      tick(1);
      if (r) begin acc++; d[0] = d[0] + 8'h01; end
    end
    vld[0] = 1'b0;
    check("accepted", 0, acc, 17);
    check("full_cnt", 0, int'(cnt[0]), 16);
    check("full_rdy", 0, int'(rdy[0]), 0);
    tick(1800);
    check("drained", 0, int'(busy[0]), 0);

    // Test 6: reset in DATA of the second of three queued frames.
    d[0] = 8'hA1; vld[0] = 1'b1; tick(3); vld[0] = 1'b0;
    tick(128);
    check("pre_rst_busy", 0, int'(busy[0]), 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst6_txd", 0, int'(txd[0]), 1);
    check("rst6_cnt", 0, int'(cnt[0]), 0);
    tick(300);
    check("no_resume", 0, int'(busy[0]), 0);
    d[0] = 8'h3C; vld[0] = 1'b1; tick(1); vld[0] = 1'b0;
    tick(150);

    // Random traffic with varying density and rare resets.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 1800; c++) begin
        for (int i = 0; i < N; i++) begin
          vld[i] = ($urandom_range(0, 7) < 2 * ph + 1);
          d[i]   = 8'($urandom);
        end
        rst = ($urandom_range(0, 1499) == 0);
        tick(1);
      end
    end
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    rst = 1'b0;
    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an internal transmit FIFO; successor to the fixed-format RS-232 sender driven from CLOCK_50.
- Generalises baud rate, data width, parity mode and stop-bit count, and adds a valid/ready byte interface with buffering so frames go out back-to-back with no idle gap.
- Sits between on-chip producers and the board UART_TXD pin.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate. Bit period DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles; DIV must be ≥ 2.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16, entries; must be a power of 2, ≥ 2.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  FIFO can accept; equals (fifo_count < FIFO_DEPTH).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.
- tx_busy  out  1  high while the FSM is outside IDLE.
- UART_TXD  out  1  serial line; idles high.

Behaviour:
- Reset values (after any edge with RESET=1): UART_TXD=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, baud and bit counters=0.
- Reset overrides everything, including mid-frame: the line returns high on that edge, the FIFO is emptied, and no partial frame resumes.
- Write handshake: a write occurs on an edge with tx_valid & tx_ready. With tx_ready=0, tx_data is neither consumed nor lost; the producer holds it.
- A simultaneous push and pop leaves fifo_count unchanged.
- tx_ready does not anticipate a same-cycle pop.
- FIFO is a circular buffer. Pointers wrap at FIFO_DEPTH.
- FSM states are IDLE, START, DATA, PAR, STOP.
- IDLE → START: on an edge where the FIFO is non-empty. The head entry is popped into the shift register and UART_TXD is driven 0 from that edge.
  - Latency: a write accepted at edge k into an empty FIFO with the FSM idle produces the falling start edge at k+1.
- Each state holds for exactly DIV cycles, counted by the baud counter running 0..DIV-1.
- DATA: sends DATA_BITS bits, LSB first; each bit is held DIV cycles.
- DATA → PAR if PARITY≠0, otherwise DATA → STOP.
- PAR: even mode drives XOR of the data bits; odd mode drives its inverse. The frame including the parity bit therefore has even or odd total ones respectively.
- STOP: drives 1 for STOP_BITS × DIV cycles.
- At the end of STOP: if the FIFO is non-empty, pop and go directly to START on the same edge (zero idle cycles); otherwise go to IDLE.
- Frame length = DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- UART_TXD is registered; it is never combinational from FIFO contents.
- tx_data is captured at the write edge. Later changes to tx_data do not affect a buffered entry.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state enum;
  - divisor function calc_div(CLK_HZ, BAUD);
  - frame-length function for benches.
- Sub-module sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/count/full/empty. The top holds the baud counter, bit counter, shift register and FSM.

Test Plan:
- All tests use CLK_HZ=50000000 and BAUD=5000000, so DIV=10.
- Test 1, defaults (8N1), write 0x55 at edge k:
  - UART_TXD falls at k+1;
  - line sequence per 10-cycle slot is 0,1,0,1,0,1,0,1,0,1;
  - then high;
  - tx_busy drops after 100 cycles.
- Test 2, PARITY=2, write 0x07 → the 9th slot after start (parity) is 1, frame length 110.
- Test 3, PARITY=1, write 0x07 → parity slot is 0.
- Test 4, STOP_BITS=2, write 0xFF → line low for 10 cycles, then high for 100, frame 110, no start edge inside.
- Test 5, FIFO_DEPTH=16, hold tx_valid 30 cycles from idle with incrementing data:
  - exactly 17 writes accepted;
  - tx_ready=0 with fifo_count=16 until the first frame ends;
  - 17 frames transmitted contiguously in 1700 cycles with no extra high cycle;
  - data order preserved.
- Test 6, RESET pulsed during DATA of the second of three queued frames → UART_TXD=1 and fifo_count=0 after the edge, no further start bit; a write afterwards transmits normally.
